// File: rtl/seq_linear_mac_layer.sv
// Time-multiplexed fully-connected layer: one signed multiplier walks all N_OUT*N_IN products,
// then bias, arithmetic shift, optional ReLU and saturation per output neuron.
module seq_linear_mac_layer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int IN_W  = 8,
  parameter int W_W   = 8,
  parameter int B_W   = 16,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8,
  parameter int SHIFT = 7,
  parameter int RELU  = 1,
  localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int BA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  input  logic [N_IN*IN_W-1:0]     in_vec,
  output logic [WA_W-1:0]          w_addr,
  input  logic [W_W-1:0]           w_data,
  output logic [BA_W-1:0]          b_addr,
  input  logic [B_W-1:0]           b_data,
  output logic [N_OUT*OUT_W-1:0]   out_vec
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW = IN_W + W_W;
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] OMAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (ACC_W < IN_W + W_W + $clog2(N_IN) + 1) begin : g_acc_width_check
    $error("seq_linear_mac_layer: ACC_W too narrow for N_IN products of IN_W x W_W");
  end

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d;
  logic [BA_W-1:0]           j_q, j_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [IN_W-1:0]    in_q [N_IN];
  logic signed [IN_W-1:0]    in_d [N_IN];
  logic [N_OUT*OUT_W-1:0]    out_q, out_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [IN_W-1:0]    x_s;
  logic signed [W_W-1:0]     w_s;
  logic signed [B_W-1:0]     b_s;
  logic signed [PW-1:0]      prod;
  logic signed [SW-1:0]      biased;
  logic signed [SW-1:0]      shifted;
  logic signed [OUT_W-1:0]   r_out;

  function automatic logic signed [SW-1:0] relu_f(input logic signed [SW-1:0] x);
    if (RELU != 0 && x[SW-1]) return '0;
    return x;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_f(input logic signed [SW-1:0] x);
    if (x > OMAX) return {1'b0, {(OUT_W-1){1'b1}}};
    if (x < OMIN) return {1'b1, {(OUT_W-1){1'b0}}};
    return x[OUT_W-1:0];
  endfunction

  // Shared datapath: one product per MAC cycle, one post-processed result per ACT cycle
  assign x_s     = in_q[i_q];
  assign w_s     = w_data;
  assign b_s     = b_data;
  assign prod    = x_s * w_s;
  assign biased  = SW'(acc_q) + SW'(b_s);
  assign shifted = biased >>> SHIFT;
  assign r_out   = sat_f(relu_f(shifted));

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    in_d        = in_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    busy        = 1'b0;
    done        = 1'b0;
    w_addr      = '0;
    b_addr      = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < N_IN; k++) in_d[k] = in_vec[k*IN_W +: IN_W];
          i_d         = '0;
          j_d         = '0;
          acc_d       = '0;
          out_valid_d = 1'b0;
          state_d     = MAC;
        end
      end
      MAC: begin
        busy   = 1'b1;
        w_addr = WA_W'(32'(j_q) * 32'(N_IN) + 32'(i_q));
        acc_d  = acc_q + ACC_W'(prod);
        if (i_q == IW'(N_IN - 1)) state_d = ACT;
        else                      i_d     = i_q + 1'b1;
      end
      ACT: begin
        busy   = 1'b1;
        b_addr = j_q;
        out_d[int'(j_q)*OUT_W +: OUT_W] = r_out;
        acc_d  = '0;
        i_d    = '0;
        if (j_q == BA_W'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = MAC;
        end
      end
      DONE: begin
        done        = 1'b1;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < N_IN; k++) in_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_q        <= in_d;
    end
  end

  assign out_vec   = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_linear_mac_layer.sv
// Scoreboard bench for seq_linear_mac_layer: a ReLU and a linear instance share stimulus,
// plus a small N_IN=3/N_OUT=2 linear instance; a reference model predicts every result.
module tb_seq_linear_mac_layer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start  = 1'b0;
  logic [31:0] in_vec = '0;
  logic        busy, done, out_valid;
  logic [3:0]  w_addr;
  logic [1:0]  b_addr;
  logic [7:0]  w_data;
  logic [15:0] b_data;
  logic [31:0] out_vec;

  logic        busy_l, done_l, ov_l;
  logic [3:0]  w_addr_l;
  logic [1:0]  b_addr_l;
  logic [7:0]  w_data_l;
  logic [15:0] b_data_l;
  logic [31:0] out_l;

  logic        start_s  = 1'b0;
  logic [23:0] in_vec_s = '0;
  logic        busy_s, done_s, ov_s;
  logic [2:0]  w_addr_s;
  logic [0:0]  b_addr_s;
  logic [7:0]  w_data_s;
  logic [15:0] b_data_s;
  logic [15:0] out_s;

  logic [7:0]  Wt [16];
  logic [15:0] Bt [4];
  logic [7:0]  cur_in [4];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb_main [$];
  logic [31:0] sb_lin  [$];
  logic [15:0] sb_s    [$];

  assign w_data   = Wt[w_addr];
  assign b_data   = Bt[b_addr];
  assign w_data_l = Wt[w_addr_l];
  assign b_data_l = Bt[b_addr_l];
  assign w_data_s = Wt[w_addr_s];
  assign b_data_s = Bt[b_addr_s];

  seq_linear_mac_layer #(.RELU(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .out_valid(out_valid),
    .in_vec(in_vec), .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .out_vec(out_vec)
  );

  seq_linear_mac_layer #(.RELU(0)) dut_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_l), .done(done_l), .out_valid(ov_l),
    .in_vec(in_vec), .w_addr(w_addr_l), .w_data(w_data_l), .b_addr(b_addr_l), .b_data(b_data_l),
    .out_vec(out_l)
  );

  seq_linear_mac_layer #(.N_IN(3), .N_OUT(2), .RELU(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s), .out_valid(ov_s),
    .in_vec(in_vec_s), .w_addr(w_addr_s), .w_data(w_data_s), .b_addr(b_addr_s), .b_data(b_data_s),
    .out_vec(out_s)
  );

  function automatic logic [31:0] model(int n_in, int n_out, bit relu);
    logic [31:0] res = '0;
    longint acc, r;
    for (int j = 0; j < n_out; j++) begin
      acc = 0;
      for (int i = 0; i < n_in; i++)
        acc += longint'($signed(cur_in[i])) * longint'($signed(Wt[j*n_in+i]));
      acc += longint'($signed(Bt[j]));
      r = acc >>> 7;
      if (relu && r < 0) r = 0;
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
      res[j*8 +: 8] = r[7:0];
    end
    return res;
  endfunction

  task automatic load(input logic [7:0] x, input logic [7:0] w, input logic [15:0] bstep);
    for (int i = 0; i < 4; i++)  cur_in[i] = x;
    for (int k = 0; k < 16; k++) Wt[k] = w;
    for (int j = 0; j < 4; j++)  Bt[j] = 16'(int'(bstep) * (j + 1));
  endtask

  task automatic randomize_all();
    for (int i = 0; i < 4; i++)  cur_in[i] = 8'($urandom);
    for (int k = 0; k < 16; k++) Wt[k] = 8'($urandom);
    for (int j = 0; j < 4; j++)  Bt[j] = 16'($urandom_range(0, 4000)) - 16'd2000;
  endtask

  task automatic launch();
    sb_main.push_back(model(4, 4, 1'b1));
    sb_lin.push_back(model(4, 4, 1'b0));
    for (int i = 0; i < 4; i++) in_vec[i*8 +: 8] = cur_in[i];
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit to);
    bit seen = 1'b0;
    cyc = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      cyc++;
      seen = done;
    end
    to = !seen;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, out_valid, w_addr, b_addr, out_vec} !== '0) begin
      n_err++;
      $display("FAIL reset_main: got %h required 0", {busy, done, out_valid, w_addr, b_addr, out_vec});
    end
    n_cmp++;
    if ({busy_l, done_l, ov_l, w_addr_l, b_addr_l, out_l, busy_s, done_s, ov_s, out_s} !== '0) begin
      n_err++;
      $display("FAIL reset_others: got %h required 0",
               {busy_l, done_l, ov_l, w_addr_l, b_addr_l, out_l, busy_s, done_s, ov_s, out_s});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc; bit to;
    logic [31:0] e;
    load(8'd1, 8'd127, 16'd0);
    launch();
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy: busy=%b out_valid=%b required busy=1 out_valid=0", busy, out_valid);
    end
    wait_done(cyc, to);
    n_cmp++;
    if (to || cyc !== 20) begin
      n_err++;
      $display("FAIL basic_latency: got %0d cycles (timeout=%0b) required 20", cyc, to);
    end
    n_cmp++;
    if (done_l !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done_lin: got %b required 1", done_l);
    end
    e = sb_main.pop_front();
    n_cmp++;
    if (out_vec !== e) begin
      n_err++;
      $display("FAIL basic_out: got %h required %h", out_vec, e);
    end
    e = sb_lin.pop_front();
    n_cmp++;
    if (out_l !== e) begin
      n_err++;
      $display("FAIL basic_out_lin: got %h required %h", out_l, e);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, out_valid, busy, ov_l} !== 4'b0101) begin
      n_err++;
      $display("FAIL basic_after_done: done,out_valid,busy,ov_l=%b required 0101",
               {done, out_valid, busy, ov_l});
    end
  endtask

  task automatic run_pair(input string name);
    int cyc; bit to;
    logic [31:0] e;
    launch();
    wait_done(cyc, to);
    n_cmp++;
    if (to) begin
      n_err++;
      $display("FAIL %s_timeout: no done within 100 cycles", name);
    end
    e = sb_main.pop_front();
    n_cmp++;
    if (out_vec !== e) begin
      n_err++;
      $display("FAIL %s_relu: got %h required %h", name, out_vec, e);
    end
    e = sb_lin.pop_front();
    n_cmp++;
    if (out_l !== e) begin
      n_err++;
      $display("FAIL %s_linear: got %h required %h", name, out_l, e);
    end
    @(negedge clk);
  endtask

  task automatic test_negative();
    load(8'd1, 8'h81, 16'd0);
    run_pair("negative");
  endtask

  task automatic test_saturation();
    load(8'd127, 8'd127, 16'd0);
    run_pair("sat_pos");
    load(8'd127, 8'h81, 16'd0);
    run_pair("sat_neg");
  endtask

  task automatic test_bias_addr();
    int bad_w = 0;
    logic [31:0] e;
    load(8'd0, 8'd5, 16'd256);
    launch();
    for (int p = 0; p < 20; p++) begin
      if (p > 0) @(negedge clk);
      if (p % 5 == 4) begin
        n_cmp++;
        if (b_addr !== 2'(p / 5) || w_addr !== 4'd0) begin
          n_err++;
          $display("FAIL bias_b_addr: cycle %0d b_addr=%0d w_addr=%0d required b_addr=%0d w_addr=0",
                   p, b_addr, w_addr, p / 5);
        end
      end else if (w_addr !== 4'((p / 5) * 4 + p % 5) || b_addr !== 2'd0) begin
        bad_w++;
      end
    end
    n_cmp++;
    if (bad_w != 0) begin
      n_err++;
      $display("FAIL bias_w_addr: %0d MAC cycles with wrong addresses, required 0", bad_w);
    end
    @(negedge clk);
    e = sb_main.pop_front();
    n_cmp++;
    if (done !== 1'b1 || out_vec !== e) begin
      n_err++;
      $display("FAIL bias_out: done=%b out=%h required done=1 out=%h", done, out_vec, e);
    end
    e = sb_lin.pop_front();
    n_cmp++;
    if (out_l !== e) begin
      n_err++;
      $display("FAIL bias_out_lin: got %h required %h", out_l, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    logic [31:0] e, first;
    randomize_all();
    launch();
    cyc = 0;
    to  = 1'b1;
    for (int n = 0; n < 100 && to; n++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        start  = 1'b1;
        in_vec = ~in_vec;
      end
      if (cyc == 6) start = 1'b0;
      if (done) to = 1'b0;
    end
    n_cmp++;
    if (to || cyc !== 20) begin
      n_err++;
      $display("FAIL ignore_latency: got %0d cycles (timeout=%0b) required 20", cyc, to);
    end
    e = sb_main.pop_front();
    first = e;
    n_cmp++;
    if (out_vec !== e) begin
      n_err++;
      $display("FAIL ignore_out: got %h required %h", out_vec, e);
    end
    e = sb_lin.pop_front();
    n_cmp++;
    if (out_l !== e) begin
      n_err++;
      $display("FAIL ignore_out_lin: got %h required %h", out_l, e);
    end
    launch();
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b out_valid=%b required busy=1 out_valid=0", busy, out_valid);
    end
    wait_done(cyc, to);
    n_cmp++;
    if (to || cyc !== 20) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d cycles (timeout=%0b) required 20", cyc, to);
    end
    e = sb_main.pop_front();
    n_cmp++;
    if (out_vec !== e || out_vec !== first) begin
      n_err++;
      $display("FAIL b2b_out: got %h required %h", out_vec, first);
    end
    e = sb_lin.pop_front();
    n_cmp++;
    if (out_l !== e) begin
      n_err++;
      $display("FAIL b2b_out_lin: got %h required %h", out_l, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    logic [31:0] e;
    launch();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, out_valid, w_addr, b_addr, out_vec} !== '0) begin
      n_err++;
      $display("FAIL midreset_main: got %h required 0", {busy, done, out_valid, w_addr, b_addr, out_vec});
    end
    n_cmp++;
    if ({busy_l, ov_l, out_l} !== '0) begin
      n_err++;
      $display("FAIL midreset_lin: got %h required 0", {busy_l, ov_l, out_l});
    end
    sb_main.delete();
    sb_lin.delete();
    @(negedge clk) rst_n = 1'b1;
    launch();
    wait_done(cyc, to);
    n_cmp++;
    if (to || cyc !== 20) begin
      n_err++;
      $display("FAIL midreset_latency: got %0d cycles (timeout=%0b) required 20", cyc, to);
    end
    e = sb_main.pop_front();
    n_cmp++;
    if (out_vec !== e) begin
      n_err++;
      $display("FAIL midreset_out: got %h required %h", out_vec, e);
    end
    e = sb_lin.pop_front();
    n_cmp++;
    if (out_l !== e) begin
      n_err++;
      $display("FAIL midreset_out_lin: got %h required %h", out_l, e);
    end
    @(negedge clk);
  endtask

  task automatic test_small_config();
    int cyc; bit to;
    logic [15:0] e;
    randomize_all();
    sb_s.push_back(model(3, 2, 1'b0) & 32'h0000_ffff);
    for (int i = 0; i < 3; i++) in_vec_s[i*8 +: 8] = cur_in[i];
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    n_cmp++;
    if (busy_s !== 1'b1) begin
      n_err++;
      $display("FAIL small_busy: got %b required 1", busy_s);
    end
    cyc = 0;
    to  = 1'b1;
    for (int n = 0; n < 100 && to; n++) begin
      @(negedge clk);
      cyc++;
      if (done_s) to = 1'b0;
    end
    n_cmp++;
    if (to || cyc !== 8) begin
      n_err++;
      $display("FAIL small_latency: got %0d cycles (timeout=%0b) required 8", cyc, to);
    end
    e = sb_s.pop_front();
    n_cmp++;
    if (out_s !== e) begin
      n_err++;
      $display("FAIL small_out: got %h required %h", out_s, e);
    end
    @(negedge clk);
    n_cmp++;
    if (ov_s !== 1'b1) begin
      n_err++;
      $display("FAIL small_out_valid: got %b required 1", ov_s);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_bias_addr();
    test_back_to_back();
    test_reset_mid();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
